// File: rtl/spi_tx_master.sv
// SPI mode-0 master: sends one DATA_W-bit frame MSB first per handshake and
// captures miso on every sclk rising edge; all outputs come straight from flops.
module spi_tx_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 5,
    parameter int GAP_CYC = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              miso,
    output logic              sclk,
    output logic              ssn,
    output logic              mosi,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = 8;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                tx_ready_q, tx_ready_d;
    logic                sclk_q, sclk_d;
    logic                ssn_q, ssn_d;
    logic                mosi_q, mosi_d;
    logic                done_q, done_d;
    logic                div_end;
    logic                gap_end;

    assign div_end = (cnt_q == DIV_LAST);
    assign gap_end = (cnt_q == GAP_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = tx_ready_q;
        sclk_d     = sclk_q;
        ssn_d      = ssn_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // tx_ready_q is 1 throughout IDLE, so tx_valid alone is the handshake
                if (tx_valid) begin
                    tx_sh_d    = tx_data;
                    mosi_d     = tx_data[DATA_W-1];
                    ssn_d      = 1'b0;
                    tx_ready_d = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = LEAD;
                end
            end
            LEAD, LOW: begin
                if (div_end) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_end) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = TRAIL;
                    end else begin
                        tx_sh_d   = tx_sh_q << 1;
                        mosi_d    = tx_sh_q[DATA_W-2];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = LOW;
                    end
                end
            end
            TRAIL: begin
                if (div_end) begin
                    cnt_d     = '0;
                    ssn_d     = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_end) begin
                    cnt_d      = '0;
                    tx_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b1;
            sclk_q     <= 1'b0;
            ssn_q      <= 1'b1;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            sclk_q     <= sclk_d;
            ssn_q      <= ssn_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign sclk     = sclk_q;
    assign ssn      = ssn_q;
    assign mosi     = mosi_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Bench for spi_tx_master: default instance plus a DATA_W=8/CLK_DIV=2 instance,
// with a serial-line monitor acting as the slave-side reference.
module tb_spi_tx_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready, sclk, ssn, mosi, done, miso;
    logic [15:0] rx_data;

    logic        tx_valid_s;
    logic [7:0]  tx_data_s;
    logic        tx_ready_s, sclk_s, ssn_s, mosi_s, done_s;
    logic [7:0]  rx_data_s;

    int          mode;       // 0 loopback, 1 miso=1, 2 random, 3 miso=0
    logic        miso_rand;
    int          n_checks = 0;
    int          n_fail   = 0;

    // slave-side view of the current frame, restarted on each ssn fall
    int          rises, low_cyc, dones;
    logic [15:0] mosi_w, miso_w;
    logic        ssn_prev, sclk_prev;

    always #5 clk = ~clk;

    assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : (mode == 3) ? 1'b0 : miso_rand;

    spi_tx_master u_dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .miso(miso), .sclk(sclk), .ssn(ssn), .mosi(mosi),
        .done(done), .rx_data(rx_data)
    );

    spi_tx_master #(.DATA_W(8), .CLK_DIV(2), .GAP_CYC(10)) u_small (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_s), .tx_data(tx_data_s),
        .tx_ready(tx_ready_s), .miso(1'b1), .sclk(sclk_s), .ssn(ssn_s), .mosi(mosi_s),
        .done(done_s), .rx_data(rx_data_s)
    );

    initial begin
        rises = 0; low_cyc = 0; dones = 0; mosi_w = '0; miso_w = '0;
        ssn_prev = 1'b1; sclk_prev = 1'b0; miso_rand = 1'b0;
    end

    always @(negedge clk) begin
        if (!ssn) begin
            if (ssn_prev) begin
                rises = 0; low_cyc = 0; dones = 0; mosi_w = '0; miso_w = '0;
            end
            low_cyc++;
        end
        if (sclk && !sclk_prev) begin
            rises++;
            mosi_w = {mosi_w[14:0], mosi};
            miso_w = {miso_w[14:0], miso};
        end
        if (done) dones++;
        ssn_prev  = ssn;
        sclk_prev = sclk;
        miso_rand = 1'($urandom_range(0, 1));
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input int md, input logic [15:0] exp_rx,
                        input bit use_model, input bit poke);
        int n;
        int hi;
        mode = md;
        n = 0;
        while (!tx_ready && n < 400) begin tick; n++; end
        tx_data  = d;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
        n = 1;
        while (!tx_ready && n < 400) begin
            if (poke && n == 60) begin
                tx_valid = 1'b1;
                tx_data  = 16'h1234;
            end else if (poke && n == 61) begin
                tx_valid = 1'b0;
            end
            tick;
            n++;
        end
        check("ready_latency", n, 176);
        check("mosi_bits", mosi_w, d);
        check("sclk_rises", rises, 16);
        check("ssn_low_cycles", low_cyc, 165);
        check("done_pulses", dones, 1);
        check("rx_data", rx_data, use_model ? miso_w : exp_rx);
        if (poke) begin
            hi = 0;
            repeat (20) begin tick; if (ssn) hi++; end
            check("no_extra_frame", hi, 20);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          md;
        logic [15:0] exp_rx;
        bit          poke;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, hi, rdy, r0, low_s, rs, period, last_rise;
        logic [7:0] mw;
        logic prev;

        vecs[0] = '{16'hA5C3, 0, 16'hA5C3, 1'b0};
        vecs[1] = '{16'hBEEF, 0, 16'hBEEF, 1'b0};
        vecs[2] = '{16'h0000, 1, 16'hFFFF, 1'b0};
        vecs[3] = '{16'hFFFF, 3, 16'h0000, 1'b0};
        vecs[4] = '{16'h5A5A, 0, 16'h5A5A, 1'b1};

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; mode = 0;
        tx_valid_s = 1'b0; tx_data_s = '0;
        #1;
        check("reset_outputs", {tx_ready, ssn, sclk, mosi, done}, 5'b11000);
        check("reset_rx_data", rx_data, 0);
        check("reset_small_outputs", {tx_ready_s, ssn_s, sclk_s}, 3'b110);
        repeat (3) tick;
        reset = 1'b0;
        repeat (5) tick;
        check("post_release_outputs", {tx_ready, ssn, sclk, mosi, done}, 5'b11000);

        foreach (vecs[i]) send(vecs[i].data, vecs[i].md, vecs[i].exp_rx, 1'b0, vecs[i].poke);

        for (int k = 0; k < 6; k++) send(16'($urandom), 2, '0, 1'b1, 1'b0);

        // back-to-back frames with tx_valid held high
        mode = 0; tx_data = 16'h0001; tx_valid = 1'b1;
        n = 0;
        while (ssn && n < 400) begin tick; n++; end
        while (!ssn && n < 400) begin tick; n++; end
        hi = 0; rdy = 0;
        while (ssn && n < 400) begin
            hi++;
            if (tx_ready) rdy++;
            tick; n++;
        end
        tx_valid = 1'b0;
        check("b2b_ssn_high", hi, 11);
        check("b2b_ready_high", rdy, 1);
        n = 0;
        while (!tx_ready && n < 400) begin tick; n++; end
        check("b2b_rx_data", rx_data, 16'h0001);
        check("b2b_done_pulses", dones, 1);

        // asynchronous reset at the 8th sclk rise
        mode = 0; tx_data = 16'hC3A5; tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        n = 0;
        while (rises < 8 && n < 400) begin tick; n++; end
        check("reached_8th_rise", rises, 8);
        #1 reset = 1'b1;
        #1;
        check("async_reset_outputs", {tx_ready, ssn, sclk, mosi, done}, 5'b11000);
        check("async_reset_rx_data", rx_data, 0);
        tick;
        reset = 1'b0;
        r0 = rises;
        repeat (30) tick;
        check("no_sclk_after_reset", rises, r0);
        check("no_done_after_reset", dones, 0);
        send(16'hFFFF, 0, 16'hFFFF, 1'b0, 1'b0);

        // small instance: DATA_W=8, CLK_DIV=2, miso held high
        tx_data_s = 8'h81; tx_valid_s = 1'b1;
        tick;
        tx_valid_s = 1'b0;
        n = 0; low_s = 0; rs = 0; period = 0; last_rise = -1; mw = '0; prev = 1'b0;
        while (!tx_ready_s && n < 200) begin
            if (!ssn_s) low_s++;
            if (sclk_s && !prev) begin
                if (last_rise >= 0) period = n - last_rise;
                last_rise = n;
                mw = {mw[6:0], mosi_s};
                rs++;
            end
            prev = sclk_s;
            tick; n++;
        end
        check("small_ssn_low", low_s, 34);
        check("small_sclk_period", period, 4);
        check("small_rises", rs, 8);
        check("small_mosi_bits", mw, 8'h81);
        check("small_rx_data", rx_data_s, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_tx_master.md
SPI_TX_MASTER -- requirements
Module: spi_tx_master

Interface
REQ-001 SHALL have parameter DATA_W, 16, bits per frame (legal 2..32).
REQ-002 SHALL have parameter CLK_DIV, 5, clk cycles per sclk half-period (legal 2..255); the default gives 10 MHz sclk from 100 MHz clk.
REQ-003 SHALL have parameter GAP_CYC, 10, minimum clk cycles ssn stays high between frames (legal 1..255).
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_data  input  DATA_W  frame to send, MSB first.
REQ-008 SHALL have port tx_ready  output  1  block idle and able to accept a frame.
REQ-009 SHALL have port miso  input  1  serial data from the slave.
REQ-010 SHALL have port sclk  output  1  SPI clock, idle low (mode 0).
REQ-011 SHALL have port ssn  output  1  active-low slave select.
REQ-012 SHALL have port mosi  output  1  serial data to the slave.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-014 SHALL have port rx_data  output  DATA_W  frame captured from miso, MSB first.

Function
REQ-015 All outputs SHALL be registered. No output may be combinationally driven from an input.
REQ-016 The FSM SHALL have the states IDLE, LEAD, HIGH, LOW, TRAIL and GAP. A single half-period counter SHALL time every state except IDLE.
REQ-017 In IDLE: tx_ready=1, ssn=1, sclk=0, mosi=0.
REQ-018 A handshake SHALL occur on a clk edge with tx_valid=1 and tx_ready=1. On that edge the block SHALL latch tx_data into the shift register, drive ssn to 0 and mosi to tx_data[DATA_W-1], drive tx_ready to 0, and enter LEAD.
REQ-019 LEAD SHALL last CLK_DIV cycles, then drive sclk to 1 and enter HIGH.
REQ-020 On every clk edge that drives sclk 0->1, miso SHALL be shifted into the rx shift register LSB.
REQ-021 HIGH SHALL last CLK_DIV cycles, then drive sclk to 0. If the bit counter equals DATA_W-1, the block SHALL enter TRAIL. Otherwise it SHALL shift the tx register, drive mosi to the next bit, increment the bit counter and enter LOW.
REQ-022 LOW SHALL last CLK_DIV cycles, then drive sclk to 1 and enter HIGH.
REQ-023 mosi SHALL change only on sclk falling edges or at the handshake, so mosi is stable CLK_DIV cycles before and after each sclk rising edge.
REQ-024 TRAIL SHALL last CLK_DIV cycles, then:
- drive ssn to 1 and mosi to 0
- load rx_data from the rx shift register
- pulse done for exactly one cycle
- enter GAP.
REQ-025 GAP SHALL last GAP_CYC cycles, then enter IDLE with tx_ready=1.
REQ-026 ssn low time SHALL be exactly (2*DATA_W+1)*CLK_DIV cycles. Exactly DATA_W sclk rising edges SHALL occur per frame.
REQ-027 Handshake-to-next-tx_ready latency SHALL be (2*DATA_W+1)*CLK_DIV+GAP_CYC+1 cycles, which is 176 at defaults.
REQ-028 tx_valid while tx_ready=0 SHALL be ignored. Changes on tx_data after the handshake SHALL have no effect on the frame in flight.
REQ-029 A tx_valid held high continuously SHALL start a new frame on the first cycle tx_ready returns to 1. That is back-to-back frames separated by GAP_CYC+1 cycles of ssn high.
REQ-030 rx_data SHALL hold its value between frames and update only with done.
REQ-031 The bit counter SHALL be wide enough for DATA_W-1 and SHALL never wrap within a frame.

Reset
REQ-032 Asserting reset SHALL force, immediately and without waiting for clk, every output listed below regardless of state:
- state to IDLE
- tx_ready to 1, ssn to 1
- sclk, mosi and done to 0
- rx_data, shift registers and counters to 0.
REQ-033 Reset mid-frame SHALL abort the frame with no done pulse, and no further sclk edges SHALL occur until a new handshake.
REQ-034 Release of reset SHALL cause no output change until the first handshake.

Verification
REQ-035 Defaults, tx_data=16'hA5C3, miso tied to mosi -> mosi serial 1010010111000011 sampled on 16 sclk rises, ssn low 165 cycles, done once, rx_data=16'hA5C3.
REQ-036 Defaults, tx_valid held high with 16'h0001 -> two frames, ssn high exactly 11 cycles between them, tx_ready high exactly 1 cycle between frames.
REQ-037 tx_valid pulsed with 16'h1234 while busy, mid-frame -> ignored, frame data unchanged, no extra frame.
REQ-038 reset asserted at the 8th sclk rise -> ssn=1, sclk=0 asynchronously, no done, rx_data=0. The next frame 16'hFFFF is sent correctly.
REQ-039 CLK_DIV=2, DATA_W=8, tx_data=8'h81, miso held 1 -> sclk period 4 cycles, ssn low 34 cycles, rx_data=8'hFF.
REQ-040 Loopback into the companion SPI receiver at defaults with tx_data=16'hBEEF -> receiver data=16'hBEEF after ssn rises.
